jkff_bank_ctrl: RTL



---
 rtl/jkff_bank_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/jkff_bank_ctrl.sv
// Two-requester command controller for a bank of JK flip-flops.
// Arbitrates round-robin and turns each command into combinational j/k patterns.
module jkff_bank_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [CNT_W-1:0] req1_cnt,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             grant_id
);
    typedef enum logic [1:0] {IDLE, EXEC, RUN, DONE} state_t;

    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_TGL  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_CNT  = 3'd5;
    localparam logic [2:0] OP_DOWN = 3'd6;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             gid_q, gid_d;
    logic             last_q, last_d;

    logic             gnt0, gnt1, accept;
    logic [2:0]       op_in;
    logic [WIDTH-1:0] data_in;
    logic [CNT_W-1:0] cnt_in;
    logic [WIDTH-1:0] up_t, dn_t;

    // When both are valid, the requester that did not win last time gets the grant.
    assign gnt0       = req0_valid && (!req1_valid || last_q);
    assign gnt1       = req1_valid && (!req0_valid || !last_q);
    assign req0_ready = (state_q == IDLE) && gnt0;
    assign req1_ready = (state_q == IDLE) && gnt1;
    assign accept     = req0_ready || req1_ready;

    assign op_in   = req1_ready ? req1_op   : req0_op;
    assign data_in = req1_ready ? req1_data : req0_data;
    assign cnt_in  = req1_ready ? req1_cnt  : req0_cnt;

    // Bit i toggles when every lower bit is 1 (up) or every lower bit is 0 (down).
    always_comb begin
        logic u, d;
        u = 1'b1;
        d = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = u;
            dn_t[i] = d;
            u = u & q[i];
            d = d & ~q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            data_q  <= '0;
            rem_q   <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        gid_d   = gid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d   = op_in;
                    data_d = data_in;
                    rem_d  = cnt_in;
                    gid_d  = req1_ready;
                    last_d = req1_ready;
                    if ((op_in == OP_CNT || op_in == OP_DOWN) && cnt_in != '0)
                        state_d = RUN;
                    else
                        state_d = EXEC;
                end
            end
            EXEC: state_d = DONE;
            RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A zero-count COUNT/DOWN falls through EXEC with j=k=0.
    always_comb begin
        j = '0;
        k = '0;
        case (state_q)
            EXEC: begin
                case (op_q)
                    OP_SET:  j = data_q;
                    OP_CLR:  k = data_q;
                    OP_TGL:  begin j = data_q; k = data_q;  end
                    OP_LOAD: begin j = data_q; k = ~data_q; end
                    default: ;
                endcase
            end
            RUN: begin
                if (op_q == OP_DOWN) begin
                    j = dn_t;
                    k = dn_t;
                end else begin
                    j = up_t;
                    k = up_t;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign grant_id = gid_q;

endmodule
